// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl
//   Host-side glue between the MMIO decode and a uart instance. Outgoing bytes
//   sit in a TX FIFO and are handed to the uart one at a time over the
//   start_tx/tx_done handshake. Received bytes are taken over the
//   rx_available/rx_clear handshake and queued in an RX FIFO for the bus.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   wr_en, wr_data             bus push into TX FIFO
//   tx_full, tx_level, tx_busy TX FIFO status (busy = data queued or frame in flight)
//   rd_en, rd_data, rx_empty   bus pop / show-ahead head of RX FIFO
//   rx_overrun, overrun_clr    sticky drop flag and its clear
//   start_tx, tx_value,        uart transmit handshake
//   tx_done
//   rx_available, rx_value,    uart receive handshake
//   rx_clear
module uart_host_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        tx_full,
    output logic [AW:0] tx_level,
    output logic        tx_busy,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        rx_empty,
    output logic        rx_overrun,
    input  logic        overrun_clr,
    output logic        start_tx,
    output logic [7:0]  tx_value,
    input  logic        tx_done,
    input  logic        rx_available,
    input  logic [7:0]  rx_value,
    output logic        rx_clear
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {T_IDLE, T_WAIT, T_REL} tx_state_t;
    typedef enum logic       {R_IDLE, R_CLR}         rx_state_t;

    // ------------------------------------------------------------------
    // TX FIFO + FSM
    // ------------------------------------------------------------------
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [AW:0]   tx_cnt;
    tx_state_t     tx_state, tx_state_nx;
    logic          tx_load, tx_pop, tx_push;

    assign tx_level = tx_cnt;
    assign tx_full  = (tx_cnt == LVL_FULL);
    assign tx_busy  = (tx_cnt != '0) || (tx_state != T_IDLE);
    // A pop in the same cycle frees the slot, so a push while full is safe:
    // the popped head has already been captured in tx_value.
    assign tx_push  = wr_en && (!tx_full || tx_pop);

    always_comb begin
        tx_state_nx = tx_state;
        tx_load     = 1'b0;
        tx_pop      = 1'b0;
        case (tx_state)
            T_IDLE: if (tx_cnt != '0) begin
                tx_load     = 1'b1;
                tx_state_nx = T_WAIT;
            end
            T_WAIT: if (tx_done) begin
                tx_pop      = 1'b1;
                tx_state_nx = T_REL;
            end
            // tx_done must fall before the next frame may be requested
            T_REL:  if (!tx_done) tx_state_nx = T_IDLE;
            default: tx_state_nx = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= T_IDLE;
            start_tx  <= 1'b0;
            tx_value  <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) tx_mem[i] <= '0;
        end else begin
            tx_state <= tx_state_nx;
            start_tx <= (tx_state_nx == T_WAIT);
            if (tx_load) tx_value <= tx_mem[tx_rd_ptr];
            if (tx_push) begin
                tx_mem[tx_wr_ptr] <= wr_data;
                tx_wr_ptr         <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop) tx_rd_ptr <= tx_rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO + FSM
    // ------------------------------------------------------------------
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [AW:0]   rx_cnt;
    rx_state_t     rx_state, rx_state_nx;
    logic          rx_req, rx_push, rx_pop, rx_drop, rx_full;

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == LVL_FULL);
    assign rd_data  = rx_mem[rx_rd_ptr];
    assign rx_pop   = rd_en && !rx_empty;
    assign rx_push  = rx_req && (!rx_full || rx_pop);
    assign rx_drop  = rx_req && rx_full && !rx_pop;

    // Only the R_IDLE -> R_CLR transition pushes, so each rx_available
    // assertion yields exactly one byte regardless of how long it is held.
    always_comb begin
        rx_state_nx = rx_state;
        rx_req      = 1'b0;
        case (rx_state)
            R_IDLE: if (rx_available) begin
                rx_req      = 1'b1;
                rx_state_nx = R_CLR;
            end
            R_CLR:  if (!rx_available) rx_state_nx = R_IDLE;
            default: rx_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= R_IDLE;
            rx_clear   <= 1'b0;
            rx_overrun <= 1'b0;
            rx_wr_ptr  <= '0;
            rx_rd_ptr  <= '0;
            rx_cnt     <= '0;
            for (int i = 0; i < DEPTH; i++) rx_mem[i] <= '0;
        end else begin
            rx_state <= rx_state_nx;
            rx_clear <= (rx_state_nx == R_CLR);
            // a drop in the same cycle wins over the clear
            if (rx_drop)          rx_overrun <= 1'b1;
            else if (overrun_clr) rx_overrun <= 1'b0;
            if (rx_push) begin
                rx_mem[rx_wr_ptr] <= rx_value;
                rx_wr_ptr         <= rx_wr_ptr + 1'b1;
            end
            if (rx_pop) rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_host_ctrl.sv
module tb_uart_host_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, rd_en, overrun_clr, tx_done, rx_available;
    logic [7:0] wr_data, rx_value;
    logic       tx_full, tx_busy, rx_empty, rx_overrun, start_tx, rx_clear;
    logic [2:0] tx_level;
    logic [7:0] rd_data, tx_value;

    int checks = 0;
    int fails  = 0;

    uart_host_ctrl #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_data(wr_data),
        .tx_full(tx_full), .tx_level(tx_level), .tx_busy(tx_busy),
        .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty),
        .rx_overrun(rx_overrun), .overrun_clr(overrun_clr),
        .start_tx(start_tx), .tx_value(tx_value), .tx_done(tx_done),
        .rx_available(rx_available), .rx_value(rx_value), .rx_clear(rx_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // all stimulus changes and all sampling happen on the falling edge
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b; tick(); wr_en = 1'b0;
    endtask

    task automatic pop_rx();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
    endtask

    // uart model: accept one frame, check it, then hold tx_done a while
    task automatic serve_tx(input logic [7:0] exp);
        int n = 0;
        while (!start_tx && n < 60) begin tick(); n++; end
        chk("tx_start_seen", start_tx, 1);
        chk("tx_value", tx_value, exp);
        tick(3);
        chk("tx_value_stable", tx_value, exp);
        chk("tx_start_held", start_tx, 1);
        tx_done = 1'b1; tick();
        chk("tx_start_drop", start_tx, 0);
        tick(2);
        chk("tx_no_restart_while_done", start_tx, 0);
        tx_done = 1'b0; tick();
    endtask

    // uart model: present one received byte, optionally with a bus pop / clear
    task automatic rx_byte(input logic [7:0] val, input logic rd, input logic clr);
        rx_available = 1'b1; rx_value = val; rd_en = rd; overrun_clr = clr;
        tick();
        rd_en = 1'b0; overrun_clr = 1'b0;
        chk("rx_clear_set", rx_clear, 1);
        rx_value = ~val;  // must not be captured a second time
        tick(2);
        chk("rx_clear_held", rx_clear, 1);
        rx_available = 1'b0; tick();
        chk("rx_clear_drop", rx_clear, 0);
    endtask

    task automatic check_pop(input string tag, input logic [7:0] exp);
        chk(tag, rd_data, exp);
        pop_rx();
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; overrun_clr = 1'b0;
        tx_done = 1'b0; rx_available = 1'b0; wr_data = '0; rx_value = '0;
        tick(2);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_rx_overrun", rx_overrun, 0);
        chk("rst_start_tx", start_tx, 0);
        chk("rst_tx_value", tx_value, 0);
        chk("rst_rx_clear", rx_clear, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1; tick();

        // 1: single byte, uart answers 20 cycles after start_tx
        push_tx(8'h55);
        chk("t1_level_after_push", tx_level, 1);
        chk("t1_no_start_same_cycle", start_tx, 0);
        chk("t1_busy", tx_busy, 1);
        tick();
        chk("t1_start", start_tx, 1);
        chk("t1_value", tx_value, 8'h55);
        tick(19);
        chk("t1_start_held", start_tx, 1);
        tx_done = 1'b1; tick();
        chk("t1_start_drop", start_tx, 0);
        chk("t1_level_pop", tx_level, 0);
        chk("t1_busy_in_rel", tx_busy, 1);
        tx_done = 1'b0; tick();
        chk("t1_idle", tx_busy, 0);

        // 2: overfill with uart stalled, then drain in order
        foreach (dut.tx_mem[i]) ;
        begin
            logic [7:0] v [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
            for (int i = 0; i < 5; i++) begin
                wr_en = 1'b1; wr_data = v[i]; tick();
            end
            wr_en = 1'b0;
            chk("t2_full", tx_full, 1);
            chk("t2_level", tx_level, 4);
            chk("t2_start_head", tx_value, 8'hA1);
            serve_tx(8'hA1);
            chk("t2_level_after_one", tx_level, 3);
            for (int i = 1; i < 4; i++) serve_tx(v[i]);
            chk("t2_level_drained", tx_level, 0);
            tick();
            chk("t2_idle", tx_busy, 0);
        end

        // 3: two received bytes, then two pops
        rx_byte(8'h3C, 1'b0, 1'b0);
        rx_byte(8'h7E, 1'b0, 1'b0);
        chk("t3_head", rd_data, 8'h3C);
        chk("t3_not_empty", rx_empty, 0);
        pop_rx();
        chk("t3_second", rd_data, 8'h7E);
        pop_rx();
        chk("t3_empty", rx_empty, 1);
        pop_rx();  // ignored while empty
        chk("t3_empty_after_bad_pop", rx_empty, 1);
        rx_byte(8'h5A, 1'b0, 1'b0);
        chk("t3_after_bad_pop_data", rd_data, 8'h5A);
        pop_rx();
        chk("t3_empty_again", rx_empty, 1);

        // 4: overrun, clear priority, push-while-full with pop
        for (int i = 0; i < 4; i++) rx_byte(8'h10 + 8'(i), 1'b0, 1'b0);
        chk("t4_no_overrun_at_four", rx_overrun, 0);
        rx_byte(8'h14, 1'b0, 1'b0);
        chk("t4_overrun", rx_overrun, 1);
        check_pop("t4_keep0", 8'h10);
        check_pop("t4_keep1", 8'h11);
        check_pop("t4_keep2", 8'h12);
        check_pop("t4_keep3", 8'h13);
        chk("t4_empty", rx_empty, 1);
        for (int i = 0; i < 4; i++) rx_byte(8'h20 + 8'(i), 1'b0, 1'b0);
        rx_byte(8'h24, 1'b0, 1'b1);
        chk("t4_set_beats_clr", rx_overrun, 1);
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
        chk("t4_cleared", rx_overrun, 0);
        rx_byte(8'h25, 1'b1, 1'b0);
        chk("t4_push_with_pop_no_overrun", rx_overrun, 0);
        check_pop("t4_fifo0", 8'h21);
        check_pop("t4_fifo1", 8'h22);
        check_pop("t4_fifo2", 8'h23);
        check_pop("t4_fifo3", 8'h25);
        chk("t4_empty_end", rx_empty, 1);

        // 5: asynchronous reset in T_WAIT / R_CLR
        push_tx(8'h77); tick();
        chk("t5_in_wait", start_tx, 1);
        rx_available = 1'b1; rx_value = 8'h42; tick();
        chk("t5_in_clr", rx_clear, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_start_async", start_tx, 0);
        chk("t5_clear_async", rx_clear, 0);
        chk("t5_tx_level", tx_level, 0);
        chk("t5_tx_busy", tx_busy, 0);
        chk("t5_rx_empty", rx_empty, 1);
        chk("t5_tx_value", tx_value, 0);
        rx_available = 1'b0;
        tick();
        rst_n = 1'b1; tick(2);
        chk("t5_quiet_after_reset", start_tx, 0);

        // 6: push + pop while full, simultaneous RX push
        push_tx(8'h61); push_tx(8'h62); push_tx(8'h63); push_tx(8'h64);
        chk("t6_full", tx_level, 4);
        chk("t6_head", tx_value, 8'h61);
        tx_done = 1'b1; wr_en = 1'b1; wr_data = 8'hF6;
        rx_available = 1'b1; rx_value = 8'h99;
        tick();
        wr_en = 1'b0;
        chk("t6_level_kept", tx_level, 4);
        chk("t6_still_full", tx_full, 1);
        chk("t6_start_drop", start_tx, 0);
        chk("t6_rx_stored", rx_empty, 0);
        chk("t6_rx_data", rd_data, 8'h99);
        tx_done = 1'b0; rx_available = 1'b0; tick();
        chk("t6_rx_clear_drop", rx_clear, 0);
        serve_tx(8'h62);
        serve_tx(8'h63);
        serve_tx(8'h64);
        serve_tx(8'hF6);
        chk("t6_drained", tx_level, 0);
        pop_rx();
        chk("t6_rx_single", rx_empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
